// File: rtl/dmas_pixel_scheduler_if.sv
// Handshake and core-side bundle for dmas_pixel_scheduler: RF sample stream in, DMAS core drive/result,
// and the beamformed pixel stream out. slave = scheduler view, master = surrounding datapath view.
interface dmas_pixel_scheduler_if #(
   parameter int PIXEL_BITS = 6
);
   logic signed [15:0]     s_data;
   logic                   s_valid;
   logic                   s_ready;

   logic                   core_clr;
   logic                   core_en;
   logic signed [15:0]     core_din;
   logic [1:0]             core_sign;
   logic signed [16:0]     core_result;

   logic signed [16:0]     m_data;
   logic [PIXEL_BITS-1:0]  m_pix;
   logic                   m_valid;
   logic                   m_ready;

   modport slave (
      input  s_data, s_valid, core_result, m_ready,
      output s_ready, core_clr, core_en, core_din, core_sign, m_data, m_pix, m_valid
   );

   modport master (
      output s_data, s_valid, core_result, m_ready,
      input  s_ready, core_clr, core_en, core_din, core_sign, m_data, m_pix, m_valid
   );
endinterface

// File: rtl/dmas_pixel_scheduler.sv
// Per-pixel sequencer for the DMAS core: clear, stream CHANNELS samples, drain the core pipeline, hold
// the result for downstream. Optional DMAS_SIGN_SPLIT_EN splits s_data into magnitude and sign.
//
// state  | meaning
// IDLE   | waiting for start, busy low
// CLEAR  | core_clr pulse, channel count reset
// LOAD   | s_ready high, each accepted sample becomes a core_en beat next cycle
// DRAIN  | wait CORE_LATENCY+1 cycles for core_result, then capture
// HOLD   | m_valid high until downstream accepts
module dmas_pixel_scheduler #(
   parameter int CHANNELS     = 128,
   parameter int CHANNEL_BITS = 8,
   parameter int PIXELS       = 64,
   parameter int PIXEL_BITS   = 6,
   parameter int CORE_LATENCY = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   dmas_pixel_scheduler_if.slave  bus
);
   localparam int DRAIN_BITS = $clog2(CORE_LATENCY + 2);
   localparam logic [CHANNEL_BITS-1:0] CH_LAST    = CHANNEL_BITS'(CHANNELS - 1);
   localparam logic [PIXEL_BITS-1:0]   PIX_LAST   = PIXEL_BITS'(PIXELS - 1);
   localparam logic [DRAIN_BITS-1:0]   DRAIN_LAST = DRAIN_BITS'(CORE_LATENCY);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_DRAIN,
      ST_HOLD
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [CHANNEL_BITS-1:0]  chan_cnt;
   logic [PIXEL_BITS-1:0]    pix_cnt;
   logic [DRAIN_BITS-1:0]    drain_cnt;
   logic                     beat;
   logic                     load_last;
   logic                     drain_tc;
   logic                     accept;
   logic signed [15:0]       din_nxt;
   logic [1:0]               sign_nxt;

   assign busy         = (state != ST_IDLE);
   assign bus.s_ready  = (state == ST_LOAD);
   assign bus.core_clr = (state == ST_CLEAR);

   // Magnitude/sign formatting of the incoming sample; -32768 has no positive twin so it saturates.
   always_comb begin
      din_nxt  = bus.s_data;
      sign_nxt = 2'b01;
`ifdef DMAS_SIGN_SPLIT_EN
      if (bus.s_data == 16'sh8000) begin
         din_nxt  = 16'sh7fff;
         sign_nxt = 2'b11;
      end else if (bus.s_data[15]) begin
         din_nxt  = -bus.s_data;
         sign_nxt = 2'b11;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      beat      = 1'b0;
      load_last = 1'b0;
      drain_tc  = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            beat      = bus.s_valid;
            load_last = bus.s_valid && (chan_cnt == CH_LAST);
            if (load_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            drain_tc = (drain_cnt == DRAIN_LAST);
            if (drain_tc) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            accept = bus.m_valid && bus.m_ready;
            if (accept) state_nxt = (pix_cnt == PIX_LAST) ? ST_IDLE : ST_CLEAR;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chan_cnt      <= '0;
         pix_cnt       <= '0;
         drain_cnt     <= '0;
         done          <= 1'b0;
         bus.core_en   <= 1'b0;
         bus.core_din  <= '0;
         bus.core_sign <= 2'b01;
         bus.m_data    <= '0;
         bus.m_pix     <= '0;
         bus.m_valid   <= 1'b0;
      end else begin
         done        <= 1'b0;
         bus.core_en <= beat;
         // core_din/core_sign hold through bubbles so the core sees a stable bus
         if (beat) begin
            bus.core_din  <= din_nxt;
            bus.core_sign <= sign_nxt;
         end
         case (state)
            ST_IDLE: begin
               if (start) pix_cnt <= '0;
            end
            ST_CLEAR: begin
               chan_cnt <= '0;
            end
            ST_LOAD: begin
               if (load_last)  drain_cnt <= '0;
               else if (beat)  chan_cnt  <= chan_cnt + 1'b1;
            end
            ST_DRAIN: begin
               if (drain_tc) begin
                  bus.m_data  <= bus.core_result;
                  bus.m_pix   <= pix_cnt;
                  bus.m_valid <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (accept) begin
                  bus.m_valid <= 1'b0;
                  if (pix_cnt == PIX_LAST) done    <= 1'b1;
                  else                     pix_cnt <= pix_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dmas_pixel_scheduler.sv
// Scoreboard bench for dmas_pixel_scheduler: small DMAS core model on the core port, expected core beats
// and pixel results queued from the driven samples, checked every falling edge.
module tb_dmas_pixel_scheduler;
   localparam int CHANNELS     = 4;
   localparam int PIXELS       = 2;
   localparam int PIXEL_BITS   = 6;
   localparam int CORE_LATENCY = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic busy;
   logic done;

   dmas_pixel_scheduler_if #(.PIXEL_BITS(PIXEL_BITS)) bus ();

   dmas_pixel_scheduler #(
      .CHANNELS     (CHANNELS),
      .CHANNEL_BITS (8),
      .PIXELS       (PIXELS),
      .PIXEL_BITS   (PIXEL_BITS),
      .CORE_LATENCY (CORE_LATENCY)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_val(input logic signed [15:0] s);
      int v = int'(s);
`ifdef DMAS_SIGN_SPLIT_EN
      if (v < -32767) v = -32767;
`endif
      return v;
   endfunction

   function automatic logic signed [15:0] exp_din(input logic signed [15:0] s);
`ifdef DMAS_SIGN_SPLIT_EN
      int v = exp_val(s);
      if (v < 0) v = -v;
      return 16'(v);
`else
      return s;
`endif
   endfunction

   function automatic logic [1:0] exp_sign(input logic signed [15:0] s);
`ifdef DMAS_SIGN_SPLIT_EN
      return (int'(s) < 0) ? 2'b11 : 2'b01;
`else
      return 2'b01;
`endif
   endfunction

   // DMAS core stand-in: signed accumulator, result delayed CORE_LATENCY cycles after the last beat
   logic signed [16:0] acc;
   logic signed [16:0] acc_nxt;
   logic signed [16:0] pipe [CORE_LATENCY];

   always_comb begin
      acc_nxt = acc;
      if (bus.core_clr)
         acc_nxt = '0;
      else if (bus.core_en)
         acc_nxt = (bus.core_sign == 2'b11) ? acc - 17'(bus.core_din) : acc + 17'(bus.core_din);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         for (int i = 0; i < CORE_LATENCY; i++) pipe[i] <= '0;
      end else begin
         acc     <= acc_nxt;
         pipe[0] <= acc_nxt;
         for (int i = 1; i < CORE_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign bus.core_result = pipe[CORE_LATENCY-1];

   // Sample driver: changes just after each rising edge
   int  vmode = 0;
   bit  tbl_mode = 1'b0;
   bit  vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic signed [15:0] tbl [4] = '{-16'sd5, 16'sd7, 16'sh8000, 16'sd0};
   int  pi = 0;
   int  tk = 0;
   bit  prev_acc = 1'b0;

   always @(posedge clk) begin
      int r;
      #1;
      if (!tbl_mode) tk = 0;
      else if (prev_acc) tk = (tk + 1) % 4;
      if (vmode == 1) begin
         bus.s_valid = vpat[pi];
         pi = (pi + 1) % 7;
      end else begin
         bus.s_valid = 1'b1;
      end
      r = int'($urandom_range(4000)) - 2000;
      bus.s_data = tbl_mode ? tbl[tk] : 16'(r);
      prev_acc = bus.s_valid && bus.s_ready;
   end

   typedef struct {
      logic signed [15:0] din;
      logic [1:0]         sign;
   } beat_t;

   typedef struct {
      logic signed [16:0] data;
      int                 pix;
   } pix_t;

   beat_t beat_q [$];
   pix_t  pix_q  [$];

   bit tb_idle = 1'b1, tb_load = 1'b0;
   bit exp_clr = 1'b0, exp_done = 1'b0, exp_en = 1'b0, exp_mv = 1'b0;
   int tb_ch = 0, tb_pix = 0, mv_cnt = 0, tb_sum = 0;
   logic signed [15:0] last_din = '0;
   logic [1:0]         last_sign = 2'b01;

   always @(negedge clk) begin
      bit    n_clr, n_done, n_en, n_mv;
      beat_t b;
      pix_t  p;
      if (!rst) begin
         chk_val("rst_busy",      busy,          0);
         chk_val("rst_done",      done,          0);
         chk_val("rst_s_ready",   bus.s_ready,   0);
         chk_val("rst_core_clr",  bus.core_clr,  0);
         chk_val("rst_core_en",   bus.core_en,   0);
         chk_val("rst_core_din",  bus.core_din,  0);
         chk_val("rst_core_sign", bus.core_sign, 1);
         chk_val("rst_m_valid",   bus.m_valid,   0);
         chk_val("rst_m_data",    bus.m_data,    0);
         chk_val("rst_m_pix",     bus.m_pix,     0);
         tb_idle = 1'b1; tb_load = 1'b0;
         exp_clr = 1'b0; exp_done = 1'b0; exp_en = 1'b0; exp_mv = 1'b0;
         tb_ch = 0; tb_pix = 0; mv_cnt = 0; tb_sum = 0;
         last_din = '0; last_sign = 2'b01;
         beat_q.delete();
         pix_q.delete();
      end else begin
         chk_val("busy",     busy,         !tb_idle);
         chk_val("core_clr", bus.core_clr, exp_clr);
         chk_val("done",     done,         exp_done);
         chk_val("s_ready",  bus.s_ready,  tb_load);
         chk_val("core_en",  bus.core_en,  exp_en);
         chk_val("m_valid",  bus.m_valid,  exp_mv);
         if (exp_en && beat_q.size() > 0) begin
            b = beat_q.pop_front();
            last_din  = b.din;
            last_sign = b.sign;
         end
         chk_val("core_din",  bus.core_din,  last_din);
         chk_val("core_sign", bus.core_sign, last_sign);
         if (exp_mv && pix_q.size() > 0) begin
            chk_val("m_data", bus.m_data, pix_q[0].data);
            chk_val("m_pix",  bus.m_pix,  pix_q[0].pix);
         end

         n_clr = 1'b0; n_done = 1'b0; n_en = 1'b0; n_mv = exp_mv;
         if (mv_cnt > 0) begin
            mv_cnt--;
            if (mv_cnt == 0) n_mv = 1'b1;
         end
         if (tb_load && bus.s_valid) begin
            n_en   = 1'b1;
            b.din  = exp_din(bus.s_data);
            b.sign = exp_sign(bus.s_data);
            beat_q.push_back(b);
            tb_sum += exp_val(bus.s_data);
            tb_ch++;
            if (tb_ch == CHANNELS) begin
               tb_load = 1'b0;
               p.data  = 17'(tb_sum);
               p.pix   = tb_pix;
               pix_q.push_back(p);
               mv_cnt  = CORE_LATENCY + 1;
            end
         end
         if (exp_clr) begin
            tb_load = 1'b1;
            tb_ch   = 0;
            tb_sum  = 0;
         end
         if (tb_idle && start) begin
            tb_idle = 1'b0;
            tb_pix  = 0;
            n_clr   = 1'b1;
         end else if (exp_mv && bus.m_ready) begin
            n_mv = 1'b0;
            if (pix_q.size() > 0) void'(pix_q.pop_front());
            if (tb_pix == PIXELS - 1) begin
               tb_idle = 1'b1;
               n_done  = 1'b1;
            end else begin
               tb_pix++;
               n_clr = 1'b1;
            end
         end
         exp_clr  = n_clr;
         exp_done = n_done;
         exp_en   = n_en;
         exp_mv   = n_mv;
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk_val("timeout_done", done, 1);
   endtask

   task automatic wait_m_valid(input int budget);
      int n = 0;
      while (bus.m_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk_val("timeout_m_valid", bus.m_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end

   initial begin
      bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // nominal frame, continuous samples, downstream always ready
      pulse_start();
      wait_done(200);

      // reset in the middle of LOAD, then a clean restart
      pulse_start();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      pulse_start();
      wait_done(200);

      // input bubbles
      vmode = 1;
      pulse_start();
      wait_done(300);
      vmode = 0;

      // downstream backpressure in HOLD
      @(posedge clk); #1 bus.m_ready = 1'b0;
      pulse_start();
      wait_m_valid(100);
      repeat (10) @(posedge clk);
      #1 bus.m_ready = 1'b1;
      wait_done(200);

      // sign/magnitude table
      @(posedge clk); #1 tbl_mode = 1'b1;
      pulse_start();
      wait_done(200);
      @(posedge clk); #1 tbl_mode = 1'b0;

      // start held through a frame and coincident with done, then a stray start while busy
      @(posedge clk); #1 start = 1'b1;
      wait_done(200);
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      pulse_start();
      wait_done(200);

      repeat (5) @(posedge clk);
      chk_val("pix_q_empty",  pix_q.size(),  0);
      chk_val("beat_q_empty", beat_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
